// File: rtl/muxl2_lane_arbiter_if.sv
// rtl/muxl2_lane_arbiter_if.sv - lane push, output handshake and FIFO status bundle for the MUXL2 lane arbiter
interface muxl2_lane_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_00;
    logic              valid_00;
    logic [DATA_W-1:0] data_11;
    logic              valid_11;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              grant_lane;
    logic              full_0;
    logic              full_1;
    logic              empty_0;
    logic              empty_1;
    logic              overflow_0;
    logic              overflow_1;

    modport master (
        output data_00, valid_00, data_11, valid_11, out_ready,
        input  data_out, valid_out, grant_lane,
        input  full_0, full_1, empty_0, empty_1, overflow_0, overflow_1
    );

    modport slave (
        input  data_00, valid_00, data_11, valid_11, out_ready,
        output data_out, valid_out, grant_lane,
        output full_0, full_1, empty_0, empty_1, overflow_0, overflow_1
    );
endinterface

// File: rtl/muxl2_lane_arbiter.sv
// rtl/muxl2_lane_arbiter.sv - two-lane FIFO round-robin scheduler feeding the MUXL2 serializer
// Define STRICT_PRIO_EN to make lane 0 always win over lane 1.
module muxl2_lane_arbiter #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                 clk_4f,
    input  logic                 reset,
    muxl2_lane_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem    [2][FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr [2];
    logic [ADDR_W-1:0] rd_ptr [2];
    logic [ADDR_W:0]   cnt    [2];
    logic [DATA_W-1:0] wdata  [2];

    logic [1:0]        push_req, push, pop, full, empty, overflow;
    logic              load, do_pop, sel, rr_ptr, grant_q;
    logic [DATA_W-1:0] data_q;
    state_t            state_q, state_d;

    always_comb begin
        wdata[0] = bus.data_00;
        wdata[1] = bus.data_11;
        push_req = {bus.valid_11, bus.valid_00};
        for (int i = 0; i < 2; i++) begin
            full[i]  = (cnt[i] == FULL_CNT);
            empty[i] = (cnt[i] == '0);
        end
        push = push_req & ~full;
    end

    assign load = (state_q == IDLE) || bus.out_ready;

    always_comb begin
        sel    = 1'b0;
        do_pop = load && (empty != 2'b11);
`ifdef STRICT_PRIO_EN
        sel = empty[0];
`else
        // Both lanes waiting: the lane not served last time goes next.
        if (empty == 2'b00) sel = ~rr_ptr;
        else                sel = empty[0];
`endif
        pop = do_pop ? (sel ? 2'b10 : 2'b01) : 2'b00;
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            if (do_pop) state_d = sel ? SERVE1 : SERVE0;
            else        state_d = IDLE;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            overflow <= 2'b00;
            data_q   <= '0;
            grant_q  <= 1'b0;
            rr_ptr   <= 1'b1;
            state_q  <= IDLE;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= wdata[i];
                    wr_ptr[i]         <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (push[i] && !pop[i])      cnt[i] <= cnt[i] + ONE_CNT;
                else if (!push[i] && pop[i]) cnt[i] <= cnt[i] - ONE_CNT;
            end
            overflow <= push_req & full;
            if (do_pop) begin
                data_q  <= mem[sel][rd_ptr[sel]];
                grant_q <= sel;
                rr_ptr  <= sel;
            end
            state_q <= state_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.valid_out  = (state_q != IDLE);
    assign bus.grant_lane = grant_q;
    assign bus.full_0     = full[0];
    assign bus.full_1     = full[1];
    assign bus.empty_0    = empty[0];
    assign bus.empty_1    = empty[1];
    assign bus.overflow_0 = overflow[0];
    assign bus.overflow_1 = overflow[1];
endmodule

// File: tb/tb_muxl2_lane_arbiter.sv
// tb/tb_muxl2_lane_arbiter.sv - directed scoreboard bench for muxl2_lane_arbiter
module tb_muxl2_lane_arbiter;
    logic clk_4f = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [8:0] exp_q [$];

    always #5 clk_4f = ~clk_4f;

    muxl2_lane_arbiter_if #(.DATA_W(8)) bus ();

    muxl2_lane_arbiter dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    // A word is transferred on the next edge whenever valid_out and out_ready are both high.
    always @(negedge clk_4f) begin
        if (reset === 1'b1 && bus.valid_out === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_word observed=%h expected=none", {bus.grant_lane, bus.data_out});
            end else begin
                check("out_word", {7'b0, bus.grant_lane, bus.data_out}, {7'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        reset        = 1'b0;
        bus.data_00  = 8'h55;
        bus.valid_00 = 1'b1;
        bus.data_11  = 8'h66;
        bus.valid_11 = 1'b1;
        bus.out_ready = 1'b0;

        // reset held with both lanes pushing
        repeat (5) tick();
        check("rst_valid_out", 16'(bus.valid_out), 16'd0);
        check("rst_empty_0", 16'(bus.empty_0), 16'd1);
        check("rst_empty_1", 16'(bus.empty_1), 16'd1);
        check("rst_full_0", 16'(bus.full_0), 16'd0);
        check("rst_overflow_0", 16'(bus.overflow_0), 16'd0);
        check("rst_data_out", 16'(bus.data_out), 16'h0000);
        reset        = 1'b1;
        bus.valid_00 = 1'b0;
        bus.valid_11 = 1'b0;
        tick();
        check("post_rst_empty_0", 16'(bus.empty_0), 16'd1);
        check("post_rst_empty_1", 16'(bus.empty_1), 16'd1);

        // both lanes, downstream always ready
        bus.out_ready = 1'b1;
`ifdef STRICT_PRIO_EN
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b0, 8'hEE});
        exp_q.push_back({1'b1, 8'hDD});
        exp_q.push_back({1'b1, 8'hCC});
`else
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b1, 8'hDD});
        exp_q.push_back({1'b0, 8'hEE});
        exp_q.push_back({1'b1, 8'hCC});
`endif
        bus.data_00 = 8'hFF; bus.valid_00 = 1'b1;
        bus.data_11 = 8'hDD; bus.valid_11 = 1'b1;
        tick();
        bus.data_00 = 8'hEE;
        bus.data_11 = 8'hCC;
        tick();
        bus.valid_00 = 1'b0;
        bus.valid_11 = 1'b0;
        check("rr_valid_0", 16'(bus.valid_out), 16'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("rr_valid_%0d", i), 16'(bus.valid_out), 16'd1);
        end
        tick();
        check("rr_idle", 16'(bus.valid_out), 16'd0);

        // stalled output, lane 0 overfilled
        bus.out_ready = 1'b0;
        bus.valid_00  = 1'b1;
        bus.data_00   = 8'h0F;
        tick();
        check("st_empty_0", 16'(bus.empty_0), 16'd0);
        exp_q.push_back({1'b0, 8'h0F});
        for (int w = 8'h10; w <= 8'h13; w++) begin
            bus.data_00 = 8'(w);
            exp_q.push_back({1'b0, 8'(w)});
            tick();
        end
        check("st_full_0", 16'(bus.full_0), 16'd1);
        check("st_no_overflow", 16'(bus.overflow_0), 16'd0);
        check("st_hold_data", 16'(bus.data_out), 16'h000F);
        bus.data_00 = 8'h14;
        tick();
        check("ovf_pulse", 16'(bus.overflow_0), 16'd1);
        check("ovf_full_0", 16'(bus.full_0), 16'd1);
        check("ovf_lane1_quiet", 16'(bus.overflow_1), 16'd0);
        bus.valid_00 = 1'b0;
        tick();
        check("ovf_clear", 16'(bus.overflow_0), 16'd0);
        check("st_valid_hold", 16'(bus.valid_out), 16'd1);

        // release the stall and drain
        bus.out_ready = 1'b1;
        repeat (5) tick();
        check("drain_idle", 16'(bus.valid_out), 16'd0);
        check("drain_data_kept", 16'(bus.data_out), 16'h0013);
        check("drain_empty_0", 16'(bus.empty_0), 16'd1);
        check("drain_full_0", 16'(bus.full_0), 16'd0);

        // lane 1 alone
        exp_q.push_back({1'b1, 8'h99});
        exp_q.push_back({1'b1, 8'h88});
        bus.valid_11 = 1'b1;
        bus.data_11  = 8'h99;
        tick();
        bus.data_11 = 8'h88;
        tick();
        bus.valid_11 = 1'b0;
        check("l1_first", {7'b0, bus.valid_out, bus.grant_lane, bus.data_out}, {7'b0, 1'b1, 1'b1, 8'h99});
        tick();
        check("l1_second", {7'b0, bus.valid_out, bus.grant_lane, bus.data_out}, {7'b0, 1'b1, 1'b1, 8'h88});
        tick();
        check("l1_idle", 16'(bus.valid_out), 16'd0);

        // reset in the middle of a drain
        bus.out_ready = 1'b0;
        bus.valid_00  = 1'b1;
        for (int w = 8'hA0; w <= 8'hA3; w++) begin
            bus.data_00 = 8'(w);
            tick();
        end
        bus.valid_00 = 1'b0;
        check("mid_head", 16'(bus.data_out), 16'h00A0);
        exp_q.push_back({1'b0, 8'hA0});
        bus.out_ready = 1'b1;
        tick();
        reset         = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        check("flush_valid_out", 16'(bus.valid_out), 16'd0);
        check("flush_empty_0", 16'(bus.empty_0), 16'd1);
        check("flush_empty_1", 16'(bus.empty_1), 16'd1);
        check("flush_data_out", 16'(bus.data_out), 16'h0000);
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        bus.valid_00  = 1'b1; bus.data_00 = 8'h5A;
        bus.valid_11  = 1'b1; bus.data_11 = 8'hA5;
        exp_q.push_back({1'b0, 8'h5A});
        exp_q.push_back({1'b1, 8'hA5});
        tick();
        bus.valid_00 = 1'b0;
        bus.valid_11 = 1'b0;
        tick();
        check("post_flush_grant0", {8'b0, bus.grant_lane, bus.data_out[6:0]}, {8'b0, 1'b0, 7'h5A});
        tick();
        check("post_flush_grant1", {7'b0, bus.grant_lane, bus.data_out}, {7'b0, 1'b1, 8'hA5});
        tick();
        check("post_flush_idle", 16'(bus.valid_out), 16'd0);

        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
